// File: rtl/button_conditioner.sv
// Push-button front end for the SLC-3 board keys: per-channel synchronizer,
// polarity normalisation, debounce filter, press/release pulses and optional auto-repeat.
module button_conditioner #(
   parameter int N_BTN           = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int ACTIVE_LOW      = 1,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);

   localparam logic            INACTIVE = (ACTIVE_LOW != 0);
   localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
   localparam int              REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int              HOLD_W   = $clog2(REP_MAX + 1);

   for (genvar g = 0; g < N_BTN; g++) begin : g_chan
      logic [SYNC_STAGES-1:0] r_sync;
      logic [DB_W-1:0]        r_dbCnt;
      logic                   r_level;
      logic                   r_press;
      logic                   r_release;
      logic                   w_pressed;
      logic                   w_differ;
      logic                   w_accept;
      logic                   w_repeatFire;

      assign w_pressed = r_sync[SYNC_STAGES-1] ^ INACTIVE;
      assign w_differ  = (w_pressed != r_level);
      assign w_accept  = w_differ && (r_dbCnt == DB_LAST);

      // The counter only advances while the synchronized input disagrees with the
      // accepted level, so any agreeing cycle restarts the stability window.
      always_ff @(posedge Clk) begin
         if (Reset) begin
            r_sync    <= {SYNC_STAGES{INACTIVE}};
            r_dbCnt   <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], btn_raw[g]};
            r_press   <= (w_accept && !r_level) || w_repeatFire;
            r_release <= w_accept && r_level;
            if (w_accept) begin
               r_level <= ~r_level;
               r_dbCnt <= '0;
            end else if (w_differ) begin
               r_dbCnt <= r_dbCnt + DB_ONE;
            end else begin
               r_dbCnt <= '0;
            end
         end
      end

      assign btn_level[g]   = r_level;
      assign btn_press[g]   = r_press;
      assign btn_release[g] = r_release;

      if (REPEAT_DELAY > 0) begin : g_repeat
         localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
         localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
         localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

         logic [HOLD_W-1:0] r_hold;
         logic              r_first;
         logic              r_repeat;

         // r_first selects the initial delay until the first repeat has fired;
         // a repeat is suppressed on the edge that accepts the release.
         assign w_repeatFire = r_level && !w_accept &&
                               (r_first ? (r_hold == DELAY_LAST) : (r_hold == PERIOD_LAST));

         always_ff @(posedge Clk) begin
            if (Reset) begin
               r_hold   <= '0;
               r_first  <= 1'b0;
               r_repeat <= 1'b0;
            end else begin
               r_repeat <= w_repeatFire;
               if (w_accept) begin
                  r_hold  <= '0;
                  r_first <= ~r_level;
               end else if (r_level) begin
                  if (w_repeatFire) begin
                     r_hold  <= '0;
                     r_first <= 1'b0;
                  end else begin
                     r_hold <= r_hold + HOLD_ONE;
                  end
               end
            end
         end

         assign btn_repeat[g] = r_repeat;
      end else begin : g_noRepeat
         assign w_repeatFire  = 1'b0;
         assign btn_repeat[g] = 1'b0;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural reference model.
module tb_button_conditioner;

   localparam int N_BTN = 2;
   localparam int SYNC  = 2;
   localparam int DEB   = 4;
   localparam int AL    = 1;
   localparam int RD    = 10;
   localparam int RP    = 3;

   logic             Clk;
   logic             Reset;
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_repeat;

   button_conditioner #(
      .N_BTN(N_BTN), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
      .ACTIVE_LOW(AL), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .Clk(Clk), .Reset(Reset), .btn_raw(btn_raw), .btn_level(btn_level),
      .btn_press(btn_press), .btn_release(btn_release), .btn_repeat(btn_repeat)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic             rst;
      logic [N_BTN-1:0] raw;
      logic [N_BTN-1:0] level;
      logic [N_BTN-1:0] press;
      logic [N_BTN-1:0] rel;
      logic [N_BTN-1:0] rep;
   } vec_t;

   int errCount   = 0;
   int checkCount = 0;

   // Reference model: raw pin history per edge, accepted level, and edge of the last initial press.
   logic [N_BTN-1:0] rawHist[$];
   logic [N_BTN-1:0] mLevel, mPress, mRel, mRep;
   int               pressEdge[N_BTN];
   int               edgeNo = 0;

   task automatic modelReset();
      rawHist.delete();
      for (int i = 0; i < SYNC + DEB; i++) rawHist.push_back({N_BTN{1'b1}});
      mLevel = '0; mPress = '0; mRel = '0; mRep = '0;
   endtask

   // A change is accepted once the last DEB synchronized samples all disagree with the level;
   // repeats fall at RD, RD+RP, RD+2RP ... edges after the initial press.
   task automatic modelStep(input logic [N_BTN-1:0] raw, input logic rst);
      logic allDiff;
      int   age;
      if (rst) begin
         modelReset();
      end else begin
         rawHist.push_front(raw);
         while (rawHist.size() > SYNC + DEB) void'(rawHist.pop_back());
         mPress = '0; mRel = '0; mRep = '0;
         for (int ch = 0; ch < N_BTN; ch++) begin
            allDiff = 1'b1;
            for (int j = 0; j < DEB; j++)
               if ((rawHist[SYNC + j][ch] ^ AL[0]) == mLevel[ch]) allDiff = 1'b0;
            if (allDiff) begin
               if (!mLevel[ch]) begin
                  mPress[ch]    = 1'b1;
                  pressEdge[ch] = edgeNo;
               end else begin
                  mRel[ch] = 1'b1;
               end
               mLevel[ch] = ~mLevel[ch];
            end else if (mLevel[ch]) begin
               age = edgeNo - pressEdge[ch];
               if (age >= RD && ((age - RD) % RP) == 0) begin
                  mPress[ch] = 1'b1;
                  mRep[ch]   = 1'b1;
               end
            end
         end
      end
      edgeNo++;
   endtask

   task automatic checkOutput(input string name, input logic [N_BTN-1:0] eL, eP, eR, eRp);
      checkCount++;
      if ({btn_level, btn_press, btn_release, btn_repeat} !== {eL, eP, eR, eRp}) begin
         errCount++;
         $display("[TB] FAIL %s @%0t: got lvl=%b prs=%b rel=%b rep=%b, expected lvl=%b prs=%b rel=%b rep=%b",
                  name, $time, btn_level, btn_press, btn_release, btn_repeat, eL, eP, eR, eRp);
      end
   endtask

   task automatic checkInt(input string name, input int got, input int exp);
      checkCount++;
      if (got != exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Drive inputs just after an edge, let the next edge sample them, then compare to the model.
   task automatic applyStimulus(input logic [N_BTN-1:0] raw, input logic rst);
      btn_raw = raw;
      Reset   = rst;
      @(posedge Clk);
      #1;
      modelStep(raw, rst);
      checkOutput("model", mLevel, mPress, mRel, mRep);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(2'b11, 1'b0);
   endtask

   vec_t             vecs[12];
   int               nPress, pressE, nRep, firstRep, lastRep, relE, nRel0, rep0After, flipOdds;
   int               pressE0, pressE1;
   logic [N_BTN-1:0] seen, rawR;
   logic             rstR;

   initial begin
      btn_raw = 2'b11;
      Reset   = 1'b1;
      modelReset();

      // Reset state followed by a clean press on channel 0 (press at the 6th edge).
      vecs[0]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[1]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[2]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[3]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
      for (int i = 4; i < 9; i++) vecs[i] = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[9]  = '{1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
      vecs[10] = '{1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
      vecs[11] = '{1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].raw, vecs[i].rst);
         checkOutput($sformatf("vec%0d", i), vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].rep);
      end
      idle(15);

      // Bounce: 2-cycle toggles never qualify; one press 6 edges after settling low.
      nPress = 0;
      for (int c = 0; c < 12; c++) begin
         applyStimulus({1'b1, (((c / 2) % 2) == 1)}, 1'b0);
         if (btn_press[0]) nPress++;
      end
      checkInt("bouncePressDuring", nPress, 0);
      pressE = -1;
      for (int e = 0; e < 10; e++) begin
         applyStimulus(2'b10, 1'b0);
         if (btn_press[0]) begin
            nPress++;
            pressE = e;
         end
      end
      checkInt("bouncePressCount", nPress, 1);
      checkInt("bouncePressEdge", pressE, 5);
      idle(15);

      // Glitch: 3 low cycles must leave channel 0 untouched.
      seen = '0;
      for (int c = 0; c < 13; c++) begin
         applyStimulus((c < 3) ? 2'b10 : 2'b11, 1'b0);
         seen = seen | btn_level | btn_press | btn_release;
      end
      checkInt("glitchActivity", int'(seen), 0);
      idle(5);

      // Auto-repeat: 30-cycle hold.
      pressE = -1; nRep = 0; firstRep = -1; lastRep = -1; relE = -1;
      for (int e = 0; e < 45; e++) begin
         applyStimulus((e < 30) ? 2'b10 : 2'b11, 1'b0);
         if (btn_press[0] && !btn_repeat[0]) pressE = e;
         if (btn_repeat[0]) begin
            nRep++;
            if (firstRep < 0) firstRep = e;
            lastRep = e;
         end
         if (btn_release[0]) relE = e;
      end
      checkInt("repeatPressEdge", pressE, 5);
      checkInt("repeatFirstEdge", firstRep, 15);
      checkInt("repeatLastEdge", lastRep, 33);
      checkInt("repeatCount", nRep, 7);
      checkInt("repeatReleaseEdge", relE, 35);
      idle(10);

      // Simultaneous press, then release channel 1 only while channel 0 keeps repeating.
      pressE0 = -1; pressE1 = -1; relE = -1; nRel0 = 0; rep0After = 0;
      for (int e = 0; e < 35; e++) begin
         applyStimulus((e < 15) ? 2'b00 : 2'b10, 1'b0);
         if (btn_press[0] && !btn_repeat[0]) pressE0 = e;
         if (btn_press[1] && !btn_repeat[1]) pressE1 = e;
         if (btn_release[1]) relE = e;
         if (btn_release[0]) nRel0++;
         if (btn_repeat[0] && e > 20) rep0After++;
      end
      checkInt("simPressEdge0", pressE0, 5);
      checkInt("simPressEdge1", pressE1, 5);
      checkInt("simReleaseEdge1", relE, 20);
      checkInt("simRelease0Count", nRel0, 0);
      checkInt("simRepeat0After", rep0After, 5);
      idle(15);

      // Reset mid-hold: outputs clear without a release, then the press re-fires.
      for (int e = 0; e < 8; e++) applyStimulus(2'b10, 1'b0);
      checkInt("midHoldLevel", int'(btn_level[0]), 1);
      applyStimulus(2'b10, 1'b1);
      checkOutput("resetMidHold", 2'b00, 2'b00, 2'b00, 2'b00);
      applyStimulus(2'b10, 1'b1);
      pressE = -1; nRel0 = 0;
      for (int e = 0; e < 10; e++) begin
         applyStimulus(2'b10, 1'b0);
         if (btn_press[0] && pressE < 0) pressE = e;
         if (btn_release[0]) nRel0++;
      end
      checkInt("resetRepressEdge", pressE, 5);
      checkInt("resetNoRelease", nRel0, 0);
      idle(15);

      // Randomized: alternating bouncy and long-hold phases with occasional resets.
      rawR = 2'b11;
      for (int blk = 0; blk < 8; blk++) begin
         flipOdds = ((blk % 2) == 0) ? 4 : 40;
         for (int c = 0; c < 100; c++) begin
            for (int ch = 0; ch < N_BTN; ch++)
               if ($urandom_range(flipOdds - 1, 0) == 0) rawR[ch] = ~rawR[ch];
            rstR = ($urandom_range(149, 0) == 0);
            applyStimulus(rawR, rstR);
         end
      end
      idle(15);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
